// File: rtl/cm_sketch_epoch_arbiter.sv
// Round-robin sharing of one count-min sketch input among NUM_REQ samplers, with epoch flush sequencing.
// One sample per grant; a grant holds sk_valid until sk_ready, and flushes stall grants for 1+FLUSH_WAIT cycles.
module cm_sketch_epoch_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_SIZE     = 22,
  parameter int EPOCH_CYCLES  = 65536,
  parameter int EPOCH_SAMPLES = 4096,
  parameter int FLUSH_WAIT    = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         epoch_force,
  output logic                         sk_valid,
  output logic [ADDR_SIZE-1:0]         sk_addr,
  output logic                         sk_query_en,
  input  logic                         sk_ready,
  output logic                         flushing,
  output logic [15:0]                  epoch_id,
  output logic [31:0]                  epoch_samples
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW_W  = (FLUSH_WAIT > 1) ? $clog2(FLUSH_WAIT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_QUERY = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [31:0]      CYC_TERM = (EPOCH_CYCLES > 0) ? 32'(EPOCH_CYCLES - 1) : 32'd0;
  localparam logic [31:0]      SMP_TERM = 32'(EPOCH_SAMPLES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(FLUSH_WAIT - 1);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [31:0]      cycle_cnt;
  logic [DW_W-1:0]  drain_cnt;
  logic             flush_pending;

  logic             arb_found;
  logic [PTR_W-1:0] arb_idx;
  logic [PTR_W:0]   cand;
  logic             accept;
  logic             counting;
  logic             cyc_at_term;
  logic [31:0]      cycle_inc;
  logic [31:0]      smp_nxt;
  logic             timer_hit;
  logic             sample_hit;
  logic             force_hit;
  logic             trigger;

  // First requester at or after rr_ptr, wrapping; rr_ptr + k never exceeds 2*NUM_REQ-2.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!arb_found && req_valid[cand[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign accept      = (state == S_XFER) && sk_valid && sk_ready;
  assign counting    = (state == S_IDLE) || (state == S_XFER);
  assign cyc_at_term = (cycle_cnt == CYC_TERM);
  assign cycle_inc   = cycle_cnt + 32'd1;
  assign smp_nxt     = (epoch_samples == 32'hFFFF_FFFF) ? epoch_samples : epoch_samples + 32'd1;

  // The timer flags on the edge it lands on its terminal value, so the flush starts one IDLE cycle later.
  assign timer_hit  = (EPOCH_CYCLES != 0) && counting && (cyc_at_term || (cycle_inc == CYC_TERM));
  assign sample_hit = (EPOCH_SAMPLES != 0) && accept && (smp_nxt == SMP_TERM);
  assign force_hit  = epoch_force && counting;
  assign trigger    = timer_hit || sample_hit || force_hit;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      cycle_cnt     <= '0;
      drain_cnt     <= '0;
      flush_pending <= 1'b0;
      sk_valid      <= 1'b0;
      sk_addr       <= '0;
      sk_query_en   <= 1'b0;
      flushing      <= 1'b0;
      epoch_id      <= '0;
      epoch_samples <= '0;
    end else begin
      if (trigger) flush_pending <= 1'b1;
      if ((EPOCH_CYCLES != 0) && counting && !cyc_at_term) cycle_cnt <= cycle_inc;

      case (state)
        S_IDLE: begin
          if (flush_pending) begin
            state       <= S_QUERY;
            sk_query_en <= 1'b1;
            flushing    <= 1'b1;
          end else if (arb_found) begin
            grant    <= arb_idx;
            sk_addr  <= req_addr[int'(arb_idx)*ADDR_SIZE +: ADDR_SIZE];
            sk_valid <= 1'b1;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (sk_ready) begin
            sk_valid      <= 1'b0;
            epoch_samples <= smp_nxt;
            rr_ptr        <= (grant == PTR_LAST) ? '0 : grant + PTR_W'(1);
            state         <= S_IDLE;
          end
        end
        S_QUERY: begin
          sk_query_en   <= 1'b0;
          epoch_id      <= epoch_id + 16'd1;
          epoch_samples <= '0;
          cycle_cnt     <= '0;
          flush_pending <= 1'b0;
          drain_cnt     <= '0;
          state         <= S_DRAIN;
        end
        default: begin
          if (drain_cnt == DW_LAST) begin
            flushing <= 1'b0;
            state    <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DW_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cm_sketch_epoch_arbiter.sv
// Directed bench for cm_sketch_epoch_arbiter: arbitration order, sample/timer/force flushes, reset in DRAIN.
module tb_cm_sketch_epoch_arbiter;

  localparam int NR = 4;
  localparam int AW = 22;
  localparam int FW = 6;
  localparam int HN = 1024;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready;
  logic              epoch_force;
  logic              sk_valid;
  logic [AW-1:0]     sk_addr;
  logic              sk_query_en;
  logic              sk_ready;
  logic              flushing;
  logic [15:0]       epoch_id;
  logic [31:0]       epoch_samples;

  cm_sketch_epoch_arbiter #(
    .NUM_REQ(NR), .ADDR_SIZE(AW), .EPOCH_CYCLES(100), .EPOCH_SAMPLES(4), .FLUSH_WAIT(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .epoch_force(epoch_force), .sk_valid(sk_valid), .sk_addr(sk_addr), .sk_query_en(sk_query_en),
    .sk_ready(sk_ready), .flushing(flushing), .epoch_id(epoch_id), .epoch_samples(epoch_samples)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle k = the k-th rising edge after rst_n release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic        h_qen  [0:HN-1];
  logic        h_flush[0:HN-1];
  logic        h_svld [0:HN-1];
  logic [15:0] h_eid  [0:HN-1];
  logic [31:0] h_esmp [0:HN-1];
  int          g_cyc[$];
  int          g_id[$];
  logic [AW-1:0] g_addr[$];
  int          q_cyc[$];
  int          overlap_cnt = 0;
  int          nonhot_cnt = 0;
  int          rdy_delay = 1;
  int          vcnt = 0;
  bit          drop_on_ready = 1'b1;

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int gid(input int i);
    return (i < g_id.size()) ? g_id[i] : -1;
  endfunction
  function automatic int gcy(input int i);
    return (i < g_cyc.size()) ? g_cyc[i] : -1;
  endfunction
  function automatic logic [AW-1:0] gad(input int i);
    return (i < g_addr.size()) ? g_addr[i] : '1;
  endfunction
  function automatic int qcy(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1;
  endfunction

  // Monitor: per-cycle history plus grant and query logs, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cyc < HN) begin
        h_qen[cyc]   = sk_query_en;
        h_flush[cyc] = flushing;
        h_svld[cyc]  = sk_valid;
        h_eid[cyc]   = epoch_id;
        h_esmp[cyc]  = epoch_samples;
        if (req_ready != '0) begin
          g_cyc.push_back(cyc);
          g_id.push_back(onehot_idx(req_ready));
          g_addr.push_back(sk_addr);
        end
        if (sk_query_en) q_cyc.push_back(cyc);
        if (sk_valid && sk_query_en) overlap_cnt++;
        if ((req_ready & (req_ready - 1'b1)) != '0) nonhot_cnt++;
      end
    end
  end

  // Sketch model: ready once sk_valid has been seen for more than rdy_delay cycles.
  initial begin
    sk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sk_valid) begin
        vcnt++;
        sk_ready = (vcnt > rdy_delay);
      end else begin
        vcnt = 0;
        sk_ready = 1'b0;
      end
    end
  end

  // Requesters release req_valid once their grant is seen, when asked to.
  initial begin
    forever begin
      @(negedge clk);
      if (drop_on_ready) req_valid = req_valid & ~req_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < HN; i++) begin
      h_qen[i] = 1'b0; h_flush[i] = 1'b0; h_svld[i] = 1'b0; h_eid[i] = '0; h_esmp[i] = '0;
    end
    g_cyc.delete(); g_id.delete(); g_addr.delete(); q_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int t2_cyc[8] = '{2, 5, 8, 11, 22, 25, 28, 31};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; epoch_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sk_valid", sk_valid, 0);
    chk("rst_sk_addr", sk_addr, 0);
    chk("rst_query_en", sk_query_en, 0);
    chk("rst_flushing", flushing, 0);
    chk("rst_epoch_id", epoch_id, 0);
    chk("rst_epoch_samples", epoch_samples, 0);

    // T1: single requester 2
    req_addr = '0;
    req_addr[0*AW +: AW] = 22'h00007;
    req_addr[1*AW +: AW] = 22'h00005;
    req_addr[2*AW +: AW] = 22'h01234;
    req_addr[3*AW +: AW] = 22'h00003;
    req_valid = 4'b0100; rdy_delay = 1; drop_on_ready = 1'b1;
    do_reset();
    wait_cyc(8);
    chk("t1_grant_cnt", g_cyc.size(), 1);
    chk("t1_grant_id", gid(0), 2);
    chk("t1_sk_addr", gad(0), 22'h01234);
    chk("t1_grant_cyc", gcy(0), 2);
    chk("t1_valid_held", h_svld[2], 1);
    chk("t1_valid_drop", h_svld[3], 0);
    chk("t1_samples_before", h_esmp[2], 0);
    chk("t1_samples_after", h_esmp[3], 1);

    // T2/T3: all requesters continuously, sample-count flush every 4 accepts
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(32'h100 + i);
    req_valid = 4'b1111; drop_on_ready = 1'b0; rdy_delay = 1;
    do_reset();
    wait_cyc(41);
    chk("t2_grant_cnt", g_cyc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_id%0d", i), gid(i), i % 4);
      chk($sformatf("t2_addr%0d", i), gad(i), AW'(32'h100 + (i % 4)));
      chk($sformatf("t2_cyc%0d", i), gcy(i), t2_cyc[i]);
    end
    chk("t3_query_cnt", q_cyc.size(), 2);
    chk("t3_query0_cyc", qcy(0), 13);
    chk("t3_query1_cyc", qcy(1), 33);
    chk("t3_samples_at_4", h_esmp[12], 4);
    chk("t3_samples_restart", h_esmp[14], 0);
    chk("t3_epoch_id_pre", h_eid[13], 0);
    chk("t3_epoch_id_1", h_eid[14], 1);
    chk("t3_epoch_id_2", h_eid[34], 2);
    chk("t3_flushing_pre", h_flush[12], 0);
    chk("t3_flushing_query", h_flush[13], 1);
    chk("t3_flushing_drain_end", h_flush[19], 1);
    chk("t3_flushing_done", h_flush[20], 0);
    req_valid = '0;

    // T4: timer-only flushes, period 100+1+FLUSH_WAIT
    drop_on_ready = 1'b1;
    do_reset();
    wait_cyc(330);
    chk("t4_query_cnt", q_cyc.size(), 3);
    chk("t4_query0_cyc", qcy(0), 100);
    chk("t4_query1_cyc", qcy(1), 207);
    chk("t4_query2_cyc", qcy(2), 314);
    chk("t4_query_width", h_qen[101], 0);
    chk("t4_epoch_id", h_eid[315], 3);
    chk("t4_flushing_drain", h_flush[106], 1);
    chk("t4_flushing_done", h_flush[107], 0);
    chk("t4_no_grants", g_cyc.size(), 0);

    // T5: force during a slow transfer
    req_addr[1*AW +: AW] = 22'h2AAAA;
    req_valid = 4'b0010; rdy_delay = 5; drop_on_ready = 1'b1;
    do_reset();
    wait_cyc(2);
    epoch_force = 1'b1;
    @(negedge clk);
    epoch_force = 1'b0;
    wait_cyc(11);
    chk("t5_grant_cnt", g_cyc.size(), 1);
    chk("t5_grant_id", gid(0), 1);
    chk("t5_grant_cyc", gcy(0), 6);
    chk("t5_sk_addr", gad(0), 22'h2AAAA);
    chk("t5_valid_during_force", h_svld[5], 1);
    chk("t5_query_cnt", q_cyc.size(), 1);
    chk("t5_query_cyc", qcy(0), 8);
    chk("t5_valid_at_query", h_svld[8], 0);
    chk("t5_samples_accepted", h_esmp[7], 1);
    chk("t5_samples_cleared", h_esmp[9], 0);
    chk("t5_epoch_id", h_eid[9], 1);

    // T6: reset while in DRAIN, then a fresh transfer at the widest address
    chk("t6_in_drain", flushing, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_sk_valid", sk_valid, 0);
    chk("t6_rst_sk_addr", sk_addr, 0);
    chk("t6_rst_query_en", sk_query_en, 0);
    chk("t6_rst_flushing", flushing, 0);
    chk("t6_rst_epoch_id", epoch_id, 0);
    chk("t6_rst_epoch_samples", epoch_samples, 0);
    req_addr[0*AW +: AW] = 22'h3FFFFF;
    req_valid = 4'b0001; rdy_delay = 0;
    do_reset();
    wait_cyc(6);
    chk("t6_grant_cnt", g_cyc.size(), 1);
    chk("t6_grant_id", gid(0), 0);
    chk("t6_grant_cyc", gcy(0), 1);
    chk("t6_sk_addr", gad(0), 22'h3FFFFF);
    chk("t6_samples", h_esmp[2], 1);
    chk("t6_epoch_id", h_eid[2], 0);
    chk("t6_no_query", q_cyc.size(), 0);

    chk("valid_query_overlap", overlap_cnt, 0);
    chk("req_ready_onehot", nonhot_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
